// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter, next-PC select, retire counter and jump-to-self halt
// Three-state sequencer (FILL/RUN/HALT) upstream of the instruction control decoder.
module pc_fetch_unit #(
  parameter int IMEM_AW = 12
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        q_imem,
  input  logic               jp,
  input  logic               jal,
  input  logic               jr,
  input  logic               bne,
  input  logic               blt,
  input  logic               bex,
  input  logic               alu_isNotEqual,
  input  logic               alu_isLessThan,
  input  logic [31:0]        data_readRegB,
  input  logic [31:0]        data_rstatus,
  input  logic               stall,
  output logic [IMEM_AW-1:0] address_imem,
  output logic [31:0]        pc_plus1,
  output logic               fetch_valid,
  output logic               halted,
  output logic [31:0]        instr_count
);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] jump_target;
  logic [31:0] branch_offset;
  logic [31:0] branch_target;
  logic [31:0] next_pc;
  logic        take_jump;
  logic        halt_hit;
  logic        unused_opcode_bits;

  // The opcode field is decoded upstream; only the immediates matter here.
  assign unused_opcode_bits = ^q_imem[31:27];

  assign jump_target   = {5'b0, q_imem[26:0]};
  assign branch_offset = {{15{q_imem[16]}}, q_imem[16:0]};
  assign branch_target = pc + 32'd1 + branch_offset;
  assign take_jump     = jp | jal;
  assign halt_hit      = !jr && take_jump && (jump_target == pc);

  assign address_imem = pc[IMEM_AW-1:0];
  assign pc_plus1     = pc + 32'd1;

  always_comb begin
    next_pc = pc + 32'd1;
    if (jr)
      next_pc = data_readRegB;
    else if (take_jump)
      next_pc = jump_target;
    else if (bex && (data_rstatus != 32'd0))
      next_pc = jump_target;
    else if (bne && alu_isNotEqual)
      next_pc = branch_target;
    else if (blt && alu_isLessThan)
      next_pc = branch_target;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_FILL;
      pc          <= 32'd0;
      instr_count <= 32'd0;
      fetch_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        ST_FILL: begin
          state       <= ST_RUN;
          fetch_valid <= 1'b1;
        end
        ST_RUN: begin
          if (!stall) begin
            pc          <= next_pc;
            instr_count <= instr_count + 32'd1;
            // A jump onto itself retires, then freezes until reset.
            if (halt_hit) begin
              state       <= ST_HALT;
              fetch_valid <= 1'b0;
              halted      <= 1'b1;
            end
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state       <= ST_FILL;
          fetch_valid <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and next-PC stage sitting directly upstream of the instruction control decoder in the single-cycle processor. Holds the architectural PC, drives the instruction-memory address, and each cycle selects the next PC from the decoder's jump and branch flags, ALU compare results and register-file data. Also supplies PC+1 for `jal` link writes, a retired-instruction counter, and a halt detector for jump-to-self.

## Interface
- `IMEM_AW`, default 12: instruction-memory address width (4096 words).
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `q_imem`  in  32  current instruction word, valid in the same cycle as `address_imem`.
- `jp`, `jal`, `jr`, `bne`, `blt`, `bex`  in  1 each  decoder flags for the current instruction.
- `alu_isNotEqual`  in  1  ALU compare result for `$rd` vs `$rs`.
- `alu_isLessThan`  in  1  ALU compare result, `$rd < $rs` signed.
- `data_readRegB`  in  32  register-file port B; carries `$rd` for `jr`.
- `data_rstatus`  in  32  current value of `$r30`.
- `stall`  in  1  holds PC and counter for this cycle.
- `address_imem`  out  IMEM_AW  `pc[IMEM_AW-1:0]`.
- `pc_plus1`  out  32  `pc + 1`, used as the `jal` link value.
- `fetch_valid`  out  1  the instruction on `q_imem` is architecturally live this cycle.
- `halted`  out  1  processor has executed jump-to-self.
- `instr_count`  out  32  number of retired instructions.

## Operation
- Internal `pc` is 32 bits. All arithmetic is mod 2^32.
- T = `{5'b0, q_imem[26:0]}`. N = `q_imem[16:0]` sign-extended to 32 bits.
- Branch target is `pc + 1 + N`.
- State machine has three states:
  - FILL: entered on reset. `fetch_valid=0`. PC is held. Advances to RUN on the next edge, regardless of `stall`.
  - RUN: `fetch_valid=1`.
  - HALT: `fetch_valid=0`, `halted=1`. PC and counter are frozen. HALT is left only by `reset`.
- Next-PC selection in RUN, when `stall=0`, in strict priority order:
  1. `jr` → `data_readRegB`.
  2. `jp` (j or jal) → T.
  3. `bex` and `data_rstatus != 0` → T.
  4. `bne` and `alu_isNotEqual` → branch target.
  5. `blt` and `alu_isLessThan` → branch target.
  6. Otherwise → `pc + 1`.
- Halt detection: in RUN with `stall=0`, `jp=1` and T == `pc` causes a transition to HALT. That instruction counts as retired. PC stays at T, which equals the current PC.
- `bex` with `data_rstatus == 0` falls through to `pc + 1`.
- The `bex` target T equal to `pc` does not halt; only `jp` does.
- `instr_count` increments by 1 on each RUN cycle with `stall=0`, including the halting jump. It wraps from 0xFFFFFFFF to 0.
- `stall=1` in RUN: PC, counter and state are all held. The decoder flags are ignored.
- `address_imem` truncates `pc`. Upper bits of `pc` are retained but not used for addressing. A jump target with bits above `IMEM_AW` set aliases in imem.
- `pc_plus1` is combinational from `pc` in every state.

## Timing
- Reset values, applied asynchronously while `reset=1`:
  - `pc=0`, `address_imem=0`, `pc_plus1=1`.
  - State FILL, `fetch_valid=0`, `halted=0`, `instr_count=0`.
- First edge after reset deasserts: FILL→RUN. The instruction at address 0 is live in the following cycle.
- Next-PC latency is one cycle: a decision made in cycle k appears on `address_imem` in cycle k+1.
- Reset asserted mid-RUN or mid-HALT: all state returns to reset values immediately, with no wait for a clock edge.
- Simultaneous `jr` and `jp` asserted: `jr` wins. The decoder never emits this, but the priority is fixed.

## Test plan
- Reset release:
  - Stimulus: hold `reset` 3 cycles, then release; keep all flags 0.
  - Required: `fetch_valid` is 0 for 1 cycle, then 1. `address_imem` reads 0, 0, 1, 2, 3. `instr_count` reaches 3 after 3 RUN cycles.
- Branch taken/not taken:
  - Stimulus: at pc=10, `bne=1`, N=-4, `alu_isNotEqual=1`. Then at pc=7, `blt=1`, N=5, `alu_isLessThan=0`.
  - Required: next PCs are 7, then 8.
- Jumps:
  - Stimulus: at pc=3, `jal=jp=1`, T=100. Then at pc=100, `jr=1`, `data_readRegB=4`.
  - Required: `pc_plus1=4` during the jal cycle. Next PCs are 100, then 4.
- `bex`:
  - Stimulus: T=50, first with `data_rstatus=0`, then with `data_rstatus=7`.
  - Required: PC goes to pc+1, then to 50.
- Stall and halt:
  - Stimulus: `stall=1` for 2 cycles at pc=5, then `jp=1` with T=5.
  - Required: PC holds at 5 and the counter holds during the stall. Then `halted=1`, `fetch_valid=0`. PC stays at 5 and the counter is +1 and frozen for 10 further cycles.
- Async reset in HALT:
  - Stimulus: pulse `reset` between clock edges.
  - Required: `halted`, `pc` and `instr_count` all read 0 before the next edge.
